// File: rtl/updown_pkg.sv
// Shared types for the up/down counter subsystem: FSM state encoding and datapath op codes.
package updown_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInc,
        StDec,
        StWaitRel
    } state_e;

    typedef logic [1:0] op_t;

    localparam op_t OP_NONE = 2'd0;
    localparam op_t OP_UP   = 2'd1;
    localparam op_t OP_DOWN = 2'd2;

endpackage

// File: rtl/updown_datapath.sv
// Count register with step/limit/wrap arithmetic, load clamping and z/m/wrap status.
module updown_datapath
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
    parameter int unsigned STEP    = 1,
    parameter int unsigned WRAP    = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  op_t              op_i,
    input  logic             ld_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] ld_val_i,
    output logic [WIDTH-1:0] c_out_o,
    output logic             z_o,
    output logic             m_o,
    output logic             wrap_o
);

    // One extra bit keeps MAX_VAL+1 representable when MAX_VAL = 2**WIDTH-1.
    localparam logic [WIDTH:0]   MaxW    = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0]   StepW   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   Modulus = MaxW + 1'b1;
    localparam logic [WIDTH-1:0] MaxN    = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH:0] cnt_ext, up_sum, up_wrapped, dn_diff, dn_wrapped, ld_ext;
    logic           up_over, dn_under;

    always_comb begin
        cnt_ext    = {1'b0, cnt_q};
        ld_ext     = {1'b0, ld_val_i};
        up_sum     = cnt_ext + StepW;
        up_wrapped = up_sum - Modulus;
        dn_diff    = cnt_ext - StepW;
        dn_wrapped = cnt_ext + Modulus - StepW;
        up_over    = cnt_ext > (MaxW - StepW);
        dn_under   = cnt_ext < StepW;

        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = (ld_ext > MaxW) ? MaxN : ld_val_i;
        end else begin
            case (op_i)
                OP_UP: begin
                    if (!up_over) begin
                        cnt_d = up_sum[WIDTH-1:0];
                    end else if (WRAP != 0) begin
                        cnt_d  = up_wrapped[WIDTH-1:0];
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = MaxN;
                    end
                end
                OP_DOWN: begin
                    if (!dn_under) begin
                        cnt_d = dn_diff[WIDTH-1:0];
                    end else if (WRAP != 0) begin
                        cnt_d  = dn_wrapped[WIDTH-1:0];
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign c_out_o = cnt_q;
    assign z_o     = (cnt_q == '0);
    assign m_o     = (cnt_q == MaxN);
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/updown_counter_sys.sv
// Push-button up/down counter: control FSM turning presses into single steps, plus datapath.
// Optional auto-repeat on held buttons is enabled with `define UPDOWN_AUTO_REPEAT_EN.
module updown_counter_sys
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_VAL    = (1 << WIDTH) - 1,
    parameter int unsigned STEP       = 1,
    parameter int unsigned WRAP       = 0,
    parameter int unsigned REPEAT_DLY = 8,
    parameter int unsigned REPEAT_PER = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             u,
    input  logic             d,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] c_out,
    output logic             z,
    output logic             m,
    output logic             wrap
);

    state_e state_q, state_d;
    op_t    op;
    logic   c_clr, c_ld;
    logic   dp_z, dp_m;

    assign c_clr = clr;
    assign c_ld  = ld & ~clr;

`ifdef UPDOWN_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned TmrW   = $clog2(RptMax + 1);

    // Timer counts cycles since the last step; the INC/DEC cycle itself is cycle 1.
    logic [TmrW-1:0] tmr_q, tmr_d, tmr_target;
    logic            rep_q, rep_d, susp_q, susp_d, dir_up_q, dir_up_d;
    logic            hold_ok;

    assign tmr_target = rep_q ? TmrW'(REPEAT_PER) : TmrW'(REPEAT_DLY);
    assign hold_ok    = dir_up_q ? (u & ~d) : (d & ~u);
`endif

    always_comb begin
        state_d = state_q;
        op      = OP_NONE;
`ifdef UPDOWN_AUTO_REPEAT_EN
        tmr_d    = tmr_q;
        rep_d    = rep_q;
        susp_d   = susp_q;
        dir_up_d = dir_up_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (u && !d) begin
                    state_d = StInc;
                end else if (d && !u) begin
                    state_d = StDec;
                end
`ifdef UPDOWN_AUTO_REPEAT_EN
                tmr_d    = '0;
                rep_d    = 1'b0;
                susp_d   = 1'b0;
                dir_up_d = u;
`endif
            end
            StInc: begin
                op      = OP_UP;
                state_d = StWaitRel;
`ifdef UPDOWN_AUTO_REPEAT_EN
                tmr_d = TmrW'(1);
`endif
            end
            StDec: begin
                op      = OP_DOWN;
                state_d = StWaitRel;
`ifdef UPDOWN_AUTO_REPEAT_EN
                tmr_d = TmrW'(1);
`endif
            end
            StWaitRel: begin
                if (!(u || d)) begin
                    state_d = StIdle;
                end
`ifdef UPDOWN_AUTO_REPEAT_EN
                else if (hold_ok && !susp_q) begin
                    if (tmr_q == tmr_target - 1'b1) begin
                        state_d = dir_up_q ? StInc : StDec;
                        rep_d   = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end else begin
                    tmr_d = '0;
                    rep_d = 1'b0;
                    if (u && d) begin
                        susp_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        // Clear parks the FSM until release so a held button cannot count afterwards.
        if (clr) begin
            state_d = StWaitRel;
`ifdef UPDOWN_AUTO_REPEAT_EN
            tmr_d  = '0;
            rep_d  = 1'b0;
            susp_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef UPDOWN_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q    <= '0;
            rep_q    <= 1'b0;
            susp_q   <= 1'b0;
            dir_up_q <= 1'b0;
        end else begin
            tmr_q    <= tmr_d;
            rep_q    <= rep_d;
            susp_q   <= susp_d;
            dir_up_q <= dir_up_d;
        end
    end
`endif

    updown_datapath #(
        .WIDTH  (WIDTH),
        .MAX_VAL(MAX_VAL),
        .STEP   (STEP),
        .WRAP   (WRAP)
    ) u_datapath (
        .clk_i   (clk),
        .rst_ni  (reset),
        .op_i    (op),
        .ld_i    (c_ld),
        .clr_i   (c_clr),
        .ld_val_i(ld_val),
        .c_out_o (c_out),
        .z_o     (dp_z),
        .m_o     (dp_m),
        .wrap_o  (wrap)
    );

    assign z = dp_z;
    assign m = dp_m;

endmodule

// File: doc/updown_counter_sys.md
Name: updown_counter_sys

Overview:
- Parametrised up/down push-button counter subsystem, the next generation of the 16-bit u/d counter top.
- A control FSM converts button presses on u/d into single count steps; the datapath holds the count.
- Adds the following over the previous generation: configurable width, limit, step and wrap/saturate mode; synchronous clear and parallel load; one-cycle wrap pulse.
- Instantiated by the board top; u/d arrive already debounced and synchronised to clk.

Parameters:
- WIDTH, 16: counter width in bits.
- MAX_VAL, 2**WIDTH-1: upper count limit; legal range 1..2**WIDTH-1.
- STEP, 1: increment/decrement amount; legal range 1..MAX_VAL.
- WRAP, 0: 0 = saturate at the limits; 1 = modular wrap over 0..MAX_VAL.
- REPEAT_DLY, 8: cycles a button is held before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_PER, 4: cycles between auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- u  in  1  up button, level, synchronous.
- d  in  1  down button, level, synchronous.
- clr  in  1  synchronous clear of the count.
- ld  in  1  synchronous load strobe.
- ld_val  in  WIDTH  load value.
- c_out  out  WIDTH  current count.
- z  out  1  high when c_out==0.
- m  out  1  high when c_out==MAX_VAL.
- wrap  out  1  one-cycle pulse on a wrap event (WRAP=1 only).

Behaviour:
- Reset (reset=0, asynchronous):
  - c_out=0, z=1, m=0, wrap=0.
  - FSM goes to IDLE.
- FSM states: IDLE, INC, DEC, WAIT_REL.
  - IDLE: u&!d -> INC; d&!u -> DEC; both high or both low -> stay IDLE, no count change.
  - INC / DEC: one cycle only. The datapath applies the step at the clock edge that ends this state; the FSM then goes to WAIT_REL.
  - WAIT_REL: stay while u|d; go to IDLE when both are low.
  - Latency: u first sampled high at edge N -> c_out updated at edge N+1, visible in cycle N+1.
- Exactly one step per press; holding a button produces no further steps unless AUTO_REPEAT_EN is defined.
- Priority per cycle: clr > ld > step.
  - clr: c_out=0 at the next edge and FSM -> WAIT_REL, so a held button does not count after the clear.
  - ld: c_out=min(ld_val, MAX_VAL); FSM state is unaffected.
  - A step in INC/DEC that coincides with clr or ld is dropped.
- Saturating arithmetic (WRAP=0):
  - up: c_out = (c_out > MAX_VAL-STEP) ? MAX_VAL : c_out+STEP.
  - down: c_out = (c_out < STEP) ? 0 : c_out-STEP.
  - wrap stays 0.
- Wrapping arithmetic (WRAP=1):
  - up: if c_out > MAX_VAL-STEP, c_out = c_out+STEP-(MAX_VAL+1) and wrap pulses; else c_out+STEP.
  - down: if c_out < STEP, c_out = c_out+(MAX_VAL+1)-STEP and wrap pulses; else c_out-STEP.
- All intermediate sums are WIDTH+1 bits wide, so there is no overflow at MAX_VAL=2**WIDTH-1.
- z, m: combinational from c_out. wrap: registered, high for exactly the one cycle after the wrapping edge.

Optional Feature:
- Macro: UPDOWN_AUTO_REPEAT_EN.
- Defined:
  - In WAIT_REL a repeat timer counts while the originally pressed button alone remains held.
  - After REPEAT_DLY cycles the FSM re-enters INC/DEC; subsequent steps follow every REPEAT_PER cycles.
  - The timer resets on any change of u/d, on clr, and on reset.
  - Pressing both buttons suspends repeat until both are released.
- Undefined: no timer logic is synthesised; REPEAT_DLY and REPEAT_PER are ignored; one step per press.

Decomposition:
- Shared package updown_pkg:
  - FSM state encoding enum (IDLE, INC, DEC, WAIT_REL).
  - Op encoding constants OP_UP and OP_DOWN.
- Sub-module updown_datapath holds the count register, step/limit/wrap arithmetic, ld clamping, z/m/wrap generation.
  - Driven by op, c_ld, c_clr from the FSM in the top.
  - Returns z and m to the FSM as status.

Test Plan:
- WIDTH=8, MAX_VAL=9, STEP=1, WRAP=0: 12 up presses -> c_out=9, m=1. Then 10 down presses -> c_out=0, z=1, wrap never pulses.
- WRAP=1, MAX_VAL=9, STEP=3: c_out=8, press up -> c_out=1, wrap high for one cycle. Press down -> c_out=8, wrap pulses again.
- Hold u for 20 cycles (no macro) -> exactly one increment, appearing one cycle after the FSM leaves IDLE. u and d high together from IDLE -> no change.
- ld_val=200 with MAX_VAL=9 -> c_out=9. clr and ld asserted together -> c_out=0. clr during a held u -> c_out stays 0 until release and re-press.
- reset asserted mid-INC with the clock stopped -> c_out=0 and z=1 immediately; after release the count resumes from IDLE.
- UPDOWN_AUTO_REPEAT_EN, REPEAT_DLY=8, REPEAT_PER=4, hold d from c_out=5 for 20 cycles -> steps at cycles 1, 9, 13, 17 -> c_out=1.
